// File: rtl/NXConstants.sv
// NXConstants: node-wide message constants shared by the mesh fabric.
//   MESSAGE_WIDTH  - width of one node message payload
//   node_message_t - packed payload type of that width
package NXConstants;

   localparam int MESSAGE_WIDTH = 32;

   typedef logic [MESSAGE_WIDTH-1:0] node_message_t;

endpackage : NXConstants

// File: rtl/nx_primitives.sv
// nx_primitives: shared types for the small fabric primitives.
//   arb_scheme_t - arbitration scheme selector for the stream arbiters
//                  ROUND_ROBIN : rotating priority after the last winner
//                  PRIORITY    : lowest valid index always wins
//                  WEIGHTED    : round-robin with per-stream burst hold
package nx_primitives;

   typedef enum logic [1:0] {
      ROUND_ROBIN = 2'd0,
      PRIORITY    = 2'd1,
      WEIGHTED    = 2'd2
   } arb_scheme_t;

endpackage : nx_primitives

// File: rtl/nx_arbiter_pick.sv
// nx_arbiter_pick: combinational rotating-priority picker.
// Scans the request vector starting at index 'start', wrapping modulo N,
// and returns the first requester found.
//   req   in  N   request vector
//   start in  IW  index given highest priority (must be < N)
//   grant out N   one-hot grant (all zero when nothing requests)
//   idx   out IW  index of the granted requester (0 when none)
//   any   out 1   at least one request present
module nx_arbiter_pick #(
   parameter int N = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   always_comb begin
      int c;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      c     = 0;
      for (int k = 0; k < N; k++) begin
         c = int'(start) + k;
         if (c >= N) begin
            c = c - N;
         end
         if (!any && req[c]) begin
            any      = 1'b1;
            idx      = IW'(c);
            grant[c] = 1'b1;
         end
      end
   end

endmodule : nx_arbiter_pick

// File: rtl/nx_stream_arbiter_weighted.sv
// nx_stream_arbiter_weighted: N-to-1 stream arbiter with a registered output
// slice and a winner tag. Scheme is fixed at elaboration (round-robin, fixed
// priority, or weighted round-robin with burst hold).
//   i_clk             in  1                    clock, rising edge
//   i_rst             in  1                    synchronous reset, active low
//   i_weights         in  STREAMS*WEIGHT_WIDTH burst length per stream (0 acts as 1)
//   i_inbound_data    in  STREAMS*WIDTH        inbound payloads, stream i at [i*WIDTH +: WIDTH]
//   i_inbound_valid   in  STREAMS              inbound valids
//   o_inbound_ready   out STREAMS              inbound readies, one-hot or zero
//   o_outbound_data   out WIDTH                registered payload
//   o_outbound_id     out ID_WIDTH             stream that produced the payload
//   o_outbound_valid  out 1                    registered valid
//   i_outbound_ready  in  1                    downstream ready
module nx_stream_arbiter_weighted
   import nx_primitives::*;
#(
   parameter int          STREAMS      = 4,
   parameter int          WIDTH        = NXConstants::MESSAGE_WIDTH,
   parameter arb_scheme_t SCHEME       = ROUND_ROBIN,
   parameter int          WEIGHT_WIDTH = 4,
   localparam int         ID_WIDTH     = (STREAMS > 1) ? $clog2(STREAMS) : 1
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [STREAMS*WEIGHT_WIDTH-1:0] i_weights,
   input  logic [STREAMS*WIDTH-1:0]        i_inbound_data,
   input  logic [STREAMS-1:0]              i_inbound_valid,
   output logic [STREAMS-1:0]              o_inbound_ready,
   output logic [WIDTH-1:0]                o_outbound_data,
   output logic [ID_WIDTH-1:0]             o_outbound_id,
   output logic                            o_outbound_valid,
   input  logic                            i_outbound_ready
);

   logic [WIDTH-1:0]        data_arr   [STREAMS];
   logic [WEIGHT_WIDTH-1:0] weight_arr [STREAMS];

   for (genvar gi = 0; gi < STREAMS; gi++) begin : g_unpack
      assign data_arr[gi]   = i_inbound_data[gi*WIDTH +: WIDTH];
      assign weight_arr[gi] = i_weights[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
   end

   logic                    valid_reg;
   logic [WIDTH-1:0]        data_reg;
   logic [ID_WIDTH-1:0]     id_reg;
   logic [ID_WIDTH-1:0]     ptr_reg;     // last winner
   logic [ID_WIDTH-1:0]     owner_reg;   // current burst owner (WEIGHTED)
   logic [WEIGHT_WIDTH-1:0] credit_reg;  // further beats the owner may still take

   logic                    load;
   logic                    hold;
   logic [ID_WIDTH-1:0]     ptr_inc;
   logic [ID_WIDTH-1:0]     start;
   logic [STREAMS-1:0]      pick_grant;
   logic [ID_WIDTH-1:0]     pick_idx;
   logic                    pick_any;
   logic [WEIGHT_WIDTH-1:0] credit_load;

   // The slice can accept a new beat when empty or when it is draining.
   assign load = !valid_reg | i_outbound_ready;

   assign ptr_inc = (ptr_reg == ID_WIDTH'(STREAMS - 1)) ? '0 : ptr_reg + ID_WIDTH'(1);

   // Burst hold: the owner stays first in line while it is valid and has
   // credit. If it is not valid the picker falls through to the others.
   assign hold = (SCHEME == WEIGHTED) && i_inbound_valid[owner_reg] && (credit_reg != '0);

   always_comb begin
      start = ptr_inc;
      if (SCHEME == PRIORITY) begin
         start = '0;
      end else if (hold) begin
         start = owner_reg;
      end
   end

   nx_arbiter_pick #(
      .N (STREAMS)
   ) u_pick (
      .req   (i_inbound_valid),
      .start (start),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // Readies are forced low while reset is asserted, independent of slice state.
   assign o_inbound_ready = pick_grant & {STREAMS{load & pick_any & i_rst}};

   // A fresh win grants max(weight,1) beats, i.e. max(weight,1)-1 beats after this one.
   assign credit_load = (weight_arr[pick_idx] == '0) ? '0
                                                     : weight_arr[pick_idx] - WEIGHT_WIDTH'(1);

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         valid_reg  <= 1'b0;
         data_reg   <= '0;
         id_reg     <= '0;
         ptr_reg    <= ID_WIDTH'(STREAMS - 1);
         owner_reg  <= '0;
         credit_reg <= '0;
      end else if (load) begin
         valid_reg <= pick_any;
         if (pick_any) begin
            data_reg  <= data_arr[pick_idx];
            id_reg    <= pick_idx;
            ptr_reg   <= pick_idx;
            owner_reg <= pick_idx;
            if (hold) begin
               credit_reg <= credit_reg - WEIGHT_WIDTH'(1);
            end else begin
               credit_reg <= credit_load;
            end
         end
      end
   end

   assign o_outbound_valid = valid_reg;
   assign o_outbound_data  = data_reg;
   assign o_outbound_id    = id_reg;

endmodule : nx_stream_arbiter_weighted

// File: tb/tb_nx_stream_arbiter_weighted.sv
// Bench for nx_stream_arbiter_weighted: three instances (round-robin,
// priority, weighted) share one stimulus. A directed table covers reset,
// saturation, backpressure, priority hand-over and weighted bursts; a random
// phase compares every instance against a behavioural model each cycle.
module tb_nx_stream_arbiter_weighted;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] weights;
   logic [31:0] data;
   logic [3:0]  valid;
   logic        oready;

   logic [3:0]  rdy [3];
   logic [7:0]  od  [3];
   logic [1:0]  oid [3];
   logic        ov  [3];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      nx_stream_arbiter_weighted #(
         .STREAMS      (4),
         .WIDTH        (8),
         .SCHEME       (gi == 0 ? nx_primitives::ROUND_ROBIN :
                        gi == 1 ? nx_primitives::PRIORITY : nx_primitives::WEIGHTED),
         .WEIGHT_WIDTH (4)
      ) u_dut (
         .i_clk            (clk),
         .i_rst            (rst_n),
         .i_weights        (weights),
         .i_inbound_data   (data),
         .i_inbound_valid  (valid),
         .o_inbound_ready  (rdy[gi]),
         .o_outbound_data  (od[gi]),
         .o_outbound_id    (oid[gi]),
         .o_outbound_valid (ov[gi]),
         .i_outbound_ready (oready)
      );
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // Weighted bursts are modelled as "beats served so far" against the
   // burst length captured when the stream won.
   logic       m_ov     [3];
   logic [1:0] m_id     [3];
   logic [7:0] m_data   [3];
   int         m_last   [3];
   int         m_owner  [3];
   int         m_served [3];
   int         m_wlen   [3];

   function automatic int first_from(input int s, input logic [3:0] v);
      for (int k = 0; k < 4; k++) begin
         int c;
         c = (s + k) % 4;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   function automatic int model_pick(input int m);
      if (valid == 4'b0) return -1;
      if (m == 1) return first_from(0, valid);
      if (m == 2 && valid[m_owner[m]] && m_served[m] < m_wlen[m]) return m_owner[m];
      return first_from(m_last[m] + 1, valid);
   endfunction

   function automatic logic [3:0] model_rdy(input int m);
      int p;
      if (!rst_n) return 4'b0;
      if (m_ov[m] && !oready) return 4'b0;
      p = model_pick(m);
      if (p < 0) return 4'b0;
      return 4'b0001 << p;
   endfunction

   task automatic model_step();
      for (int m = 0; m < 3; m++) begin
         int p;
         int w;
         if (!rst_n) begin
            m_ov[m] = 1'b0; m_id[m] = 2'd0; m_data[m] = 8'h00;
            m_last[m] = 3; m_owner[m] = 0; m_served[m] = 0; m_wlen[m] = 0;
         end else if (!m_ov[m] || oready) begin
            p = model_pick(m);
            if (p < 0) begin
               m_ov[m] = 1'b0;
            end else begin
               m_ov[m]   = 1'b1;
               m_id[m]   = 2'(p);
               m_data[m] = data[p*8 +: 8];
               if (p == m_owner[m] && m_served[m] < m_wlen[m]) begin
                  m_served[m]++;
               end else begin
                  w = int'(weights[p*4 +: 4]);
                  m_owner[m]  = p;
                  m_served[m] = 1;
                  m_wlen[m]   = (w == 0) ? 1 : w;
               end
               m_last[m] = p;
            end
         end
      end
   endtask

   always @(posedge clk) model_step();

   // ---------------- directed vector table ----------------
   typedef struct {
      int         inst;
      bit         chk;
      bit         rst_n;
      logic [3:0] v;
      bit         ordy;
      logic [15:0] w;
      logic [3:0] e_rdy;
      bit         e_ov;
      logic [1:0] e_id;
      logic [7:0] e_d;
   } vec_t;

   vec_t tab[$];

   task automatic add(input int inst, input bit chk, input bit r, input logic [3:0] v,
                      input bit o, input logic [15:0] w, input logic [3:0] er,
                      input bit eov, input logic [1:0] eid, input logic [7:0] ed);
      vec_t t;
      t.inst = inst; t.chk = chk; t.rst_n = r; t.v = v; t.ordy = o; t.w = w;
      t.e_rdy = er; t.e_ov = eov; t.e_id = eid; t.e_d = ed;
      tab.push_back(t);
   endtask

   localparam logic [15:0] W_A = 16'h1203;  // streams 0..3 weights 3,0,2,1
   localparam logic [15:0] W_B = 16'h0204;  // stream 0 weight 4, stream 2 weight 2

   initial begin
      rst_n   = 1'b0;
      valid   = 4'h0;
      oready  = 1'b1;
      data    = 32'hA3A2A1A0;
      weights = 16'h0;

      // Round-robin: reset with all valid, saturation, 5-cycle stall, drain.
      for (int i = 0; i < 3; i++) add(0, 1, 0, 4'hF, 1, 0, 4'h0, 0, 0, 8'h00);
      add(0, 1, 1, 4'hF, 1, 0, 4'h1, 0, 0, 8'h00);
      add(0, 1, 1, 4'hF, 1, 0, 4'h2, 1, 0, 8'hA0);
      add(0, 1, 1, 4'hF, 1, 0, 4'h4, 1, 1, 8'hA1);
      add(0, 1, 1, 4'hF, 1, 0, 4'h8, 1, 2, 8'hA2);
      add(0, 1, 1, 4'hF, 1, 0, 4'h1, 1, 3, 8'hA3);
      for (int i = 0; i < 5; i++) add(0, 1, 1, 4'hF, 0, 0, 4'h0, 1, 0, 8'hA0);
      add(0, 1, 1, 4'hF, 1, 0, 4'h2, 1, 0, 8'hA0);
      add(0, 1, 1, 4'hF, 1, 0, 4'h4, 1, 1, 8'hA1);
      add(0, 1, 1, 4'h0, 1, 0, 4'h0, 1, 2, 8'hA2);
      add(0, 1, 1, 4'h0, 1, 0, 4'h0, 0, 2, 8'hA2);
      // Priority: 1010 -> stream 1 until it drops, then stream 3.
      add(1, 0, 0, 4'hA, 1, 0, 4'h0, 0, 0, 8'h00);
      add(1, 1, 1, 4'hA, 1, 0, 4'h2, 0, 0, 8'h00);
      add(1, 1, 1, 4'hA, 1, 0, 4'h2, 1, 1, 8'hA1);
      add(1, 1, 1, 4'h8, 1, 0, 4'h8, 1, 1, 8'hA1);
      add(1, 1, 1, 4'h8, 1, 0, 4'h8, 1, 3, 8'hA3);
      add(1, 1, 1, 4'h0, 1, 0, 4'h0, 1, 3, 8'hA3);
      // Weighted {3,0,2,1}: 0,0,0,1,2,2,3,0...
      add(2, 0, 0, 4'hF, 1, W_A, 4'h0, 0, 0, 8'h00);
      add(2, 1, 1, 4'hF, 1, W_A, 4'h1, 0, 0, 8'h00);
      add(2, 1, 1, 4'hF, 1, W_A, 4'h1, 1, 0, 8'hA0);
      add(2, 1, 1, 4'hF, 1, W_A, 4'h1, 1, 0, 8'hA0);
      add(2, 1, 1, 4'hF, 1, W_A, 4'h2, 1, 0, 8'hA0);
      add(2, 1, 1, 4'hF, 1, W_A, 4'h4, 1, 1, 8'hA1);
      add(2, 1, 1, 4'hF, 1, W_A, 4'h4, 1, 2, 8'hA2);
      add(2, 1, 1, 4'hF, 1, W_A, 4'h8, 1, 2, 8'hA2);
      add(2, 1, 1, 4'hF, 1, W_A, 4'h1, 1, 3, 8'hA3);
      add(2, 1, 1, 4'hF, 1, W_A, 4'h1, 1, 0, 8'hA0);
      // Weighted drop-out: stream 0 leaves after 2 beats, stream 2 takes over,
      // stream 0 returns on its turn with a full 4-beat burst.
      add(2, 0, 0, 4'h5, 1, W_B, 4'h0, 0, 0, 8'h00);
      add(2, 1, 1, 4'h5, 1, W_B, 4'h1, 0, 0, 8'h00);
      add(2, 1, 1, 4'h5, 1, W_B, 4'h1, 1, 0, 8'hA0);
      add(2, 1, 1, 4'h4, 1, W_B, 4'h4, 1, 0, 8'hA0);
      add(2, 1, 1, 4'h5, 1, W_B, 4'h4, 1, 2, 8'hA2);
      add(2, 1, 1, 4'h5, 1, W_B, 4'h1, 1, 2, 8'hA2);
      add(2, 1, 1, 4'h5, 1, W_B, 4'h1, 1, 0, 8'hA0);
      add(2, 1, 1, 4'h5, 1, W_B, 4'h1, 1, 0, 8'hA0);
      add(2, 1, 1, 4'h5, 1, W_B, 4'h1, 1, 0, 8'hA0);
      add(2, 1, 1, 4'h5, 1, W_B, 4'h4, 1, 0, 8'hA0);

      @(posedge clk);
      #1;
      for (int r = 0; r < tab.size(); r++) begin
         int m;
         m       = tab[r].inst;
         rst_n   = tab[r].rst_n;
         valid   = tab[r].v;
         oready  = tab[r].ordy;
         weights = tab[r].w;
         @(negedge clk);
         if (tab[r].chk) begin
            check($sformatf("row%0d.inst%0d.ready", r, m), 32'(rdy[m]), 32'(tab[r].e_rdy));
            check($sformatf("row%0d.inst%0d.valid", r, m), 32'(ov[m]),  32'(tab[r].e_ov));
            check($sformatf("row%0d.inst%0d.id",    r, m), 32'(oid[m]), 32'(tab[r].e_id));
            check($sformatf("row%0d.inst%0d.data",  r, m), 32'(od[m]),  32'(tab[r].e_d));
            $display("row %0d inst %0d: valid_in=%b ready=%b out_valid=%0d id=%0d data=%h",
                     r, m, valid, rdy[m], ov[m], oid[m], od[m]);
         end
         @(posedge clk);
         #1;
      end

      // Random phase: all instances against the model every cycle.
      for (int cyc = 0; cyc < 1500; cyc++) begin
         rst_n  = ($urandom_range(0, 99) > 1);
         valid  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
         oready = ($urandom_range(0, 3) != 0);
         data   = $urandom;
         if ($urandom_range(0, 19) == 0) begin
            for (int s = 0; s < 4; s++) weights[s*4 +: 4] = 4'($urandom_range(0, 4));
         end
         @(negedge clk);
         for (int m = 0; m < 3; m++) begin
            check($sformatf("rnd%0d.inst%0d.ready", cyc, m), 32'(rdy[m]), 32'(model_rdy(m)));
            check($sformatf("rnd%0d.inst%0d.valid", cyc, m), 32'(ov[m]),  32'(m_ov[m]));
            check($sformatf("rnd%0d.inst%0d.id",    cyc, m), 32'(oid[m]), 32'(m_id[m]));
            check($sformatf("rnd%0d.inst%0d.data",  cyc, m), 32'(od[m]),  32'(m_data[m]));
            if (ov[m] && oready && rst_n)
               $display("cycle %0d inst %0d: beat id=%0d data=%h", cyc, m, oid[m], od[m]);
         end
         @(posedge clk);
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_nx_stream_arbiter_weighted
